// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// FSM state encoding and operation select encoding.
package mdu_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        BUSY  = 3'd2,
        FIXUP = 3'd3,
        DONE  = 3'd4
    } mdu_state_e;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

endpackage

// File: rtl/mdu_datapath.sv
// Operand, accumulator and remainder registers of the multiply/divide unit.
// Sequenced by accept/load/step/fixup strobes from the controlling FSM.
module mdu_datapath
    import mdu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             accept,
    input  logic             load,
    input  logic             step,
    input  logic             fixup,
    input  logic             op_div,
    input  logic             m_signed,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic [WIDTH-1:0] result_hi,
    output logic [WIDTH-1:0] result_lo,
    output logic             div_zero
);

    localparam logic [WIDTH-1:0] ZERO_W  = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONES_W  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    // Two's-complement negate of a WIDTH-bit value when en is set.
    function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic en);
        return en ? (ZERO_W - v) : v;
    endfunction

    logic               op_div_r;
    logic               signed_r;
    logic [WIDTH-1:0]   a_raw_r;
    logic [WIDTH-1:0]   b_raw_r;
    logic               sign_a_r;
    logic               sign_b_r;
    logic [2*WIDTH-1:0] acc_r;
    logic [2*WIDTH-1:0] mcand_r;
    logic [WIDTH-1:0]   mplier_r;   // multiplier, or dividend/quotient shift register
    logic [WIDTH-1:0]   divisor_r;
    logic [WIDTH-1:0]   rem_r;

    logic [WIDTH-1:0]   mag_a_s;
    logic [WIDTH-1:0]   mag_b_s;
    logic [2*WIDTH-1:0] acc_next_s;
    logic [WIDTH:0]     rem_shift_s;
    logic               div_fits_s;
    logic [WIDTH-1:0]   rem_sub_s;
    logic               neg_res_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   fix_hi_s;
    logic [WIDTH-1:0]   fix_lo_s;
    logic               fix_dz_s;

    // Operand magnitudes and one shift-add / restoring-divide iteration.
    always_comb begin
        mag_a_s     = neg_if(a_raw_r, signed_r & a_raw_r[WIDTH-1]);
        mag_b_s     = neg_if(b_raw_r, signed_r & b_raw_r[WIDTH-1]);
        acc_next_s  = mplier_r[0] ? (acc_r + mcand_r) : acc_r;
        rem_shift_s = {rem_r, mplier_r[WIDTH-1]};
        div_fits_s  = (rem_shift_s >= {1'b0, divisor_r});
        rem_sub_s   = rem_shift_s[WIDTH-1:0] - divisor_r;
    end

    // Sign correction and special cases applied once the iterations finish.
    always_comb begin
        neg_res_s = sign_a_r ^ sign_b_r;
        prod_s    = neg_res_s ? ({(2*WIDTH){1'b0}} - acc_r) : acc_r;
        fix_hi_s  = ZERO_W;
        fix_lo_s  = ZERO_W;
        fix_dz_s  = 1'b0;
        if (op_div_r == OP_MUL) begin
            fix_hi_s = prod_s[2*WIDTH-1:WIDTH];
            fix_lo_s = prod_s[WIDTH-1:0];
        end else if (b_raw_r == ZERO_W) begin
            fix_hi_s = a_raw_r;
            fix_lo_s = ONES_W;
            fix_dz_s = 1'b1;
        end else if (signed_r && (a_raw_r == MIN_VAL) && (b_raw_r == ONES_W)) begin
            fix_hi_s = ZERO_W;
            fix_lo_s = MIN_VAL;
        end else begin
            // Remainder follows the dividend's sign, quotient the sign product.
            fix_hi_s = neg_if(rem_r, sign_a_r);
            fix_lo_s = neg_if(mplier_r, neg_res_s);
        end
    end

    // Operand latch, iteration registers and registered results.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_div_r  <= 1'b0;
            signed_r  <= 1'b0;
            a_raw_r   <= ZERO_W;
            b_raw_r   <= ZERO_W;
            sign_a_r  <= 1'b0;
            sign_b_r  <= 1'b0;
            acc_r     <= {(2*WIDTH){1'b0}};
            mcand_r   <= {(2*WIDTH){1'b0}};
            mplier_r  <= ZERO_W;
            divisor_r <= ZERO_W;
            rem_r     <= ZERO_W;
            result_hi <= ZERO_W;
            result_lo <= ZERO_W;
            div_zero  <= 1'b0;
        end else begin
            if (accept) begin
                op_div_r <= op_div;
                signed_r <= m_signed;
                a_raw_r  <= src_a;
                b_raw_r  <= src_b;
            end
            if (load) begin
                sign_a_r  <= signed_r & a_raw_r[WIDTH-1];
                sign_b_r  <= signed_r & b_raw_r[WIDTH-1];
                acc_r     <= {(2*WIDTH){1'b0}};
                mcand_r   <= {ZERO_W, mag_a_s};
                mplier_r  <= (op_div_r == OP_DIV) ? mag_a_s : mag_b_s;
                divisor_r <= mag_b_s;
                rem_r     <= ZERO_W;
                div_zero  <= 1'b0;
            end
            if (step) begin
                if (op_div_r == OP_DIV) begin
                    rem_r    <= div_fits_s ? rem_sub_s : rem_shift_s[WIDTH-1:0];
                    mplier_r <= {mplier_r[WIDTH-2:0], div_fits_s};
                end else begin
                    acc_r    <= acc_next_s;
                    mcand_r  <= {mcand_r[2*WIDTH-2:0], 1'b0};
                    mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
                end
            end
            if (fixup) begin
                result_hi <= fix_hi_s;
                result_lo <= fix_lo_s;
                div_zero  <= fix_dz_s;
            end
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Fixed-latency iterative multiply/divide unit: control FSM and iteration counter,
// with the arithmetic in mdu_datapath.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op_div,
    input  logic             m_signed,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             ready,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] result_hi,
    output logic [WIDTH-1:0] result_lo
);

    mdu_state_e       state_r;
    mdu_state_e       state_s;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_s;
    logic             accept_s;
    logic             load_s;
    logic             step_s;
    logic             fixup_s;

    // State and iteration counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            count_r <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_s;
            count_r <= count_s;
        end
    end

    // Next-state and datapath strobes; BUSY spends one extra cycle at count 0
    // so the total latency is WIDTH+3 edges.
    always_comb begin
        state_s  = state_r;
        count_s  = count_r;
        accept_s = 1'b0;
        load_s   = 1'b0;
        step_s   = 1'b0;
        fixup_s  = 1'b0;
        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    accept_s = 1'b1;
                    state_s  = LOAD;
                end else begin
                    state_s  = state_r;
                end
            end
            LOAD: begin
                load_s  = 1'b1;
                count_s = CNT_W'(WIDTH);
                state_s = BUSY;
            end
            BUSY: begin
                if (count_r == {CNT_W{1'b0}}) begin
                    state_s = FIXUP;
                end else begin
                    step_s  = 1'b1;
                    count_s = count_r - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            FIXUP: begin
                fixup_s = 1'b1;
                state_s = DONE;
            end
            default: begin
                state_s = IDLE;
                count_s = {CNT_W{1'b0}};
            end
        endcase
    end

    assign ready = ~reset & ((state_r == IDLE) | (state_r == DONE));
    assign done  = ~reset & (state_r == DONE);

    mdu_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk       (clk),
        .reset     (reset),
        .accept    (accept_s),
        .load      (load_s),
        .step      (step_s),
        .fixup     (fixup_s),
        .op_div    (op_div),
        .m_signed  (m_signed),
        .src_a     (src_a),
        .src_b     (src_b),
        .result_hi (result_hi),
        .result_lo (result_lo),
        .div_zero  (div_zero)
    );

endmodule
